// File: rtl/checkout_pkg.sv
// Shared types and constants for the bar-code checkout sequencer.
package checkout_pkg;

  localparam int unsigned CODE_W   = 5;
  localparam int unsigned VAL_DEZ  = 10;
  localparam int unsigned VAL_DOIS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    PAY    = 3'd2,
    CHANGE = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_2    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_e;

endpackage

// File: rtl/price_lookup.sv
// Combinational item price table: price = 2 * code for codes 1..MAX_CODE.
module price_lookup
  import checkout_pkg::*;
#(
  parameter int unsigned MAX_CODE = 20,
  parameter int unsigned PRICE_W  = 8
) (
  input  logic [CODE_W-1:0]  code_i,
  output logic [PRICE_W-1:0] price_c,
  output logic               valid_c
);

  // Validate the code and form its price; invalid codes report a zero price.
  always_comb begin
    valid_c = (code_i != '0) && (32'(code_i) <= MAX_CODE);
    price_c = '0;
    if (valid_c) begin
      price_c = PRICE_W'({code_i, 1'b0});
    end
  end

endmodule

// File: rtl/checkout_sequencer.sv
// Sequences one purchase: accumulate item prices, collect coins, pay out change, signal FIM.
module checkout_sequencer
  import checkout_pkg::*;
#(
  parameter int unsigned TOTAL_W   = 8,
  parameter int unsigned MAX_TOTAL = 200,
  parameter int unsigned MAX_CODE  = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               scan_valid,
  input  logic [4:0]         I,
  input  logic               PG,
  input  logic               cancel,
  input  logic [1:0]         moneyEntered,
  output logic [TOTAL_W-1:0] total,
  output logic [TOTAL_W-1:0] paid,
  output logic               DEZ,
  output logic               DOIS,
  output logic               FIM,
  output logic               err,
  output logic               busy
);

  localparam int unsigned SUM_W = TOTAL_W + 1;
  localparam logic [SUM_W-1:0] MAX_TOT  = SUM_W'(MAX_TOTAL);
  localparam logic [SUM_W-1:0] PAID_MAX = SUM_W'({TOTAL_W{1'b1}});

  state_e             state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [TOTAL_W-1:0] paid_q, paid_d;
  logic [TOTAL_W-1:0] change_q, change_d;
  logic               dez_q, dez_d;
  logic               dois_q, dois_d;
  logic               fim_q, fim_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [TOTAL_W-1:0] price;
  logic               price_ok;
  logic [SUM_W-1:0]   scan_sum;
  logic [SUM_W-1:0]   coin_val;
  logic [SUM_W-1:0]   paid_sum;
  coin_e              coin;

  price_lookup #(
    .MAX_CODE (MAX_CODE),
    .PRICE_W  (TOTAL_W)
  ) u_price (
    .code_i  (I),
    .price_c (price),
    .valid_c (price_ok)
  );

  // State, datapath and pulse registers; reset drops the transaction with no payout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      total_q  <= '0;
      paid_q   <= '0;
      change_q <= '0;
      dez_q    <= 1'b0;
      dois_q   <= 1'b0;
      fim_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      dez_q    <= dez_d;
      dois_q   <= dois_d;
      fim_q    <= fim_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state, datapath update and output pulse generation.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    paid_d   = paid_q;
    change_d = change_q;
    dez_d    = 1'b0;
    dois_d   = 1'b0;
    err_d    = 1'b0;

    coin     = coin_e'(moneyEntered);
    scan_sum = {1'b0, total_q} + {1'b0, price};
    case (coin)
      COIN_2:  coin_val = SUM_W'(VAL_DOIS);
      COIN_10: coin_val = SUM_W'(VAL_DEZ);
      default: coin_val = '0;
    endcase
    paid_sum = {1'b0, paid_q} + coin_val;

    case (state_q)
      IDLE: begin
        if (scan_valid) begin
          if (price_ok && ({1'b0, price} <= MAX_TOT)) begin
            total_d = price;
            state_d = SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cancel) begin
          total_d = '0;
          state_d = DONE;
        end else if (scan_valid) begin
          // A scan wins over PG in the same cycle; PAY follows once PG is seen alone.
          if (price_ok && (scan_sum <= MAX_TOT)) begin
            total_d = scan_sum[TOTAL_W-1:0];
          end else begin
            err_d = 1'b1;
          end
        end else if (PG) begin
          state_d = PAY;
        end
      end
      PAY: begin
        if (cancel) begin
          change_d = paid_q;
          state_d  = CHANGE;
        end else if (paid_q >= total_q) begin
          // Completion is judged on the registered paid value; a coin in this cycle is not taken.
          change_d = paid_q - total_q;
          state_d  = CHANGE;
        end else begin
          case (coin)
            COIN_BAD: err_d = 1'b1;
            COIN_2, COIN_10: begin
              if (paid_sum > PAID_MAX) begin
                err_d = 1'b1;
              end else begin
                paid_d = paid_sum[TOTAL_W-1:0];
              end
            end
            default: ;
          endcase
        end
      end
      CHANGE: begin
        if (change_q >= TOTAL_W'(VAL_DEZ)) begin
          dez_d    = 1'b1;
          change_d = change_q - TOTAL_W'(VAL_DEZ);
        end else if (change_q >= TOTAL_W'(VAL_DOIS)) begin
          dois_d   = 1'b1;
          change_d = change_q - TOTAL_W'(VAL_DOIS);
        end else begin
          // Only a residue of 1 can be non-zero here; it is dropped and flagged.
          err_d    = (change_q != '0);
          change_d = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DONE) begin
      total_d = '0;
      paid_d  = '0;
    end

    fim_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  assign total = total_q;
  assign paid  = paid_q;
  assign DEZ   = dez_q;
  assign DOIS  = dois_q;
  assign FIM   = fim_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_checkout_sequencer.sv
// Directed self-checking bench for checkout_sequencer.
module tb_checkout_sequencer;

  logic       clock;
  logic       reset;
  logic       scan_valid;
  logic [4:0] I;
  logic       PG;
  logic       cancel;
  logic [1:0] moneyEntered;
  logic [7:0] total;
  logic [7:0] paid;
  logic       DEZ;
  logic       DOIS;
  logic       FIM;
  logic       err;
  logic       busy;

  int n_checks;
  int n_fails;

  checkout_sequencer #(
    .TOTAL_W   (8),
    .MAX_TOTAL (200),
    .MAX_CODE  (20)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .I            (I),
    .PG           (PG),
    .cancel       (cancel),
    .moneyEntered (moneyEntered),
    .total        (total),
    .paid         (paid),
    .DEZ          (DEZ),
    .DOIS         (DOIS),
    .FIM          (FIM),
    .err          (err),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic scan(input logic [4:0] code);
    scan_valid = 1'b1;
    I          = code;
    tick();
    scan_valid = 1'b0;
    I          = '0;
  endtask

  task automatic coin(input logic [1:0] m);
    moneyEntered = m;
    tick();
    moneyEntered = 2'b00;
  endtask

  task automatic pay();
    PG = 1'b1;
    tick();
    PG = 1'b0;
  endtask

  // Records DEZ/DOIS/FIM/err after each of n clock edges (bit i = edge i+1).
  task automatic observe(input int n, output logic [15:0] dz, output logic [15:0] ds,
                         output logic [15:0] fm, output logic [15:0] er);
    dz = '0; ds = '0; fm = '0; er = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      dz[i] = DEZ;
      ds[i] = DOIS;
      fm[i] = FIM;
      er[i] = err;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #6;
    n_checks++;
    if ({total, paid, DEZ, DOIS, FIM, err, busy} !== 21'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got total=%0d paid=%0d dez=%b dois=%b fim=%b err=%b busy=%b want all 0",
               total, paid, DEZ, DOIS, FIM, err, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_purchase();
    logic [15:0] dz, ds, fm, er;
    scan(5'd3);
    n_checks++;
    if ({total, busy} !== {8'd6, 1'b1}) begin
      n_fails++;
      $display("FAIL basic_scan1: got total=%0d busy=%b want 6 1", total, busy);
    end
    scan(5'd5);
    pay();
    coin(2'b10);
    coin(2'b10);
    n_checks++;
    if ({total, paid} !== {8'd16, 8'd20}) begin
      n_fails++;
      $display("FAIL basic_amounts: got total=%0d paid=%0d want 16 20", total, paid);
    end
    observe(8, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0000, 16'h0006, 16'h0008, 16'h0000}) begin
      n_fails++;
      $display("FAIL basic_payout: got dez=%h dois=%h fim=%h err=%h want 0000 0006 0008 0000",
               dz, ds, fm, er);
    end
    n_checks++;
    if ({total, paid, busy} !== 17'd0) begin
      n_fails++;
      $display("FAIL basic_cleared: got total=%0d paid=%0d busy=%b want 0 0 0", total, paid, busy);
    end
  endtask

  task automatic test_exact_payment();
    logic [15:0] dz, ds, fm, er;
    scan(5'd4);
    pay();
    for (int k = 0; k < 4; k++) coin(2'b01);
    n_checks++;
    if ({total, paid} !== {8'd8, 8'd8}) begin
      n_fails++;
      $display("FAIL exact_amounts: got total=%0d paid=%0d want 8 8", total, paid);
    end
    observe(4, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0000, 16'h0000, 16'h0002, 16'h0000}) begin
      n_fails++;
      $display("FAIL exact_payout: got dez=%h dois=%h fim=%h err=%h want 0000 0000 0002 0000",
               dz, ds, fm, er);
    end
  endtask

  task automatic test_change_dois();
    logic [15:0] dz, ds, fm, er;
    scan(5'd1);
    pay();
    coin(2'b10);
    n_checks++;
    if ({total, paid} !== {8'd2, 8'd10}) begin
      n_fails++;
      $display("FAIL dois_amounts: got total=%0d paid=%0d want 2 10", total, paid);
    end
    observe(8, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0000, 16'h001E, 16'h0020, 16'h0000}) begin
      n_fails++;
      $display("FAIL dois_payout: got dez=%h dois=%h fim=%h err=%h want 0000 001e 0020 0000",
               dz, ds, fm, er);
    end
  endtask

  task automatic test_refund_mixed();
    logic [15:0] dz, ds, fm, er;
    scan(5'd10);
    scan(5'd6);
    pay();
    coin(2'b10);
    coin(2'b10);
    for (int k = 0; k < 4; k++) coin(2'b01);
    n_checks++;
    if ({total, paid} !== {8'd32, 8'd28}) begin
      n_fails++;
      $display("FAIL mixed_amounts: got total=%0d paid=%0d want 32 28", total, paid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    observe(9, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0003, 16'h003C, 16'h0040, 16'h0000}) begin
      n_fails++;
      $display("FAIL mixed_refund: got dez=%h dois=%h fim=%h err=%h want 0003 003c 0040 0000",
               dz, ds, fm, er);
    end
  endtask

  task automatic test_errors();
    logic [15:0] dz, ds, fm, er;
    PG = 1'b1;
    moneyEntered = 2'b10;
    tick();
    PG = 1'b0;
    moneyEntered = 2'b00;
    n_checks++;
    if ({paid, busy, err} !== 10'd0) begin
      n_fails++;
      $display("FAIL idle_ignores: got paid=%0d busy=%b err=%b want 0 0 0", paid, busy, err);
    end
    scan(5'd0);
    n_checks++;
    if ({err, busy, total} !== {1'b1, 1'b0, 8'd0}) begin
      n_fails++;
      $display("FAIL code0: got err=%b busy=%b total=%0d want 1 0 0", err, busy, total);
    end
    scan(5'd25);
    n_checks++;
    if ({err, busy, total} !== {1'b1, 1'b0, 8'd0}) begin
      n_fails++;
      $display("FAIL code25: got err=%b busy=%b total=%0d want 1 0 0", err, busy, total);
    end
    scan(5'd21);
    n_checks++;
    if ({err, busy} !== 2'b10) begin
      n_fails++;
      $display("FAIL code21: got err=%b busy=%b want 1 0", err, busy);
    end
    tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fails++;
      $display("FAIL err_one_cycle: got err=%b want 0", err);
    end
    scan(5'd20);
    n_checks++;
    if ({err, busy, total} !== {1'b0, 1'b1, 8'd40}) begin
      n_fails++;
      $display("FAIL code20: got err=%b busy=%b total=%0d want 0 1 40", err, busy, total);
    end
    pay();
    coin(2'b01);
    coin(2'b11);
    n_checks++;
    if ({err, paid} !== {1'b1, 8'd2}) begin
      n_fails++;
      $display("FAIL bad_coin: got err=%b paid=%0d want 1 2", err, paid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    observe(4, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0000, 16'h0001, 16'h0002, 16'h0000}) begin
      n_fails++;
      $display("FAIL bad_coin_refund: got dez=%h dois=%h fim=%h err=%h want 0000 0001 0002 0000",
               dz, ds, fm, er);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) scan(5'd20);
    n_checks++;
    if ({total, err} !== {8'd200, 1'b0}) begin
      n_fails++;
      $display("FAIL total_at_max: got total=%0d err=%b want 200 0", total, err);
    end
    scan(5'd1);
    n_checks++;
    if ({total, err} !== {8'd200, 1'b1}) begin
      n_fails++;
      $display("FAIL total_overflow: got total=%0d err=%b want 200 1", total, err);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++;
    if ({FIM, total, busy} !== {1'b1, 8'd0, 1'b1}) begin
      n_fails++;
      $display("FAIL scan_cancel: got fim=%b total=%0d busy=%b want 1 0 1", FIM, total, busy);
    end
    tick();
    n_checks++;
    if ({FIM, busy} !== 2'b00) begin
      n_fails++;
      $display("FAIL scan_cancel_idle: got fim=%b busy=%b want 0 0", FIM, busy);
    end
  endtask

  task automatic test_cancel_refund();
    logic [15:0] dz, ds, fm, er;
    for (int k = 0; k < 3; k++) scan(5'd10);
    pay();
    coin(2'b10);
    n_checks++;
    if ({total, paid} !== {8'd60, 8'd10}) begin
      n_fails++;
      $display("FAIL refund_amounts: got total=%0d paid=%0d want 60 10", total, paid);
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    observe(4, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er} !== {16'h0001, 16'h0000, 16'h0002, 16'h0000}) begin
      n_fails++;
      $display("FAIL refund_payout: got dez=%h dois=%h fim=%h err=%h want 0001 0000 0002 0000",
               dz, ds, fm, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dz, ds, fm, er;
    scan(5'd3);
    scan_valid = 1'b1;
    I = 5'd5;
    PG = 1'b1;
    tick();
    scan_valid = 1'b0;
    I = '0;
    moneyEntered = 2'b10;
    tick();
    PG = 1'b0;
    n_checks++;
    if ({total, paid} !== {8'd16, 8'd0}) begin
      n_fails++;
      $display("FAIL b2b_scan_pg: got total=%0d paid=%0d want 16 0", total, paid);
    end
    tick();
    tick();
    moneyEntered = 2'b00;
    n_checks++;
    if (paid !== 8'd20) begin
      n_fails++;
      $display("FAIL b2b_paid: got paid=%0d want 20", paid);
    end
    observe(6, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm} !== {16'h0000, 16'h0006, 16'h0008}) begin
      n_fails++;
      $display("FAIL b2b_payout: got dez=%h dois=%h fim=%h want 0000 0006 0008", dz, ds, fm);
    end
  endtask

  task automatic test_reset_mid_change();
    logic [15:0] dz, ds, fm, er;
    scan(5'd1);
    pay();
    coin(2'b10);
    tick();
    tick();
    n_checks++;
    if (DOIS !== 1'b1) begin
      n_fails++;
      $display("FAIL midreset_pre: got dois=%b want 1", DOIS);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({total, paid, DEZ, DOIS, FIM, err, busy} !== 21'd0) begin
      n_fails++;
      $display("FAIL midreset_async: got total=%0d paid=%0d dez=%b dois=%b fim=%b err=%b busy=%b want all 0",
               total, paid, DEZ, DOIS, FIM, err, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    observe(8, dz, ds, fm, er);
    n_checks++;
    if ({dz, ds, fm, er, 7'd0, busy} !== 72'd0) begin
      n_fails++;
      $display("FAIL midreset_after: got dez=%h dois=%h fim=%h err=%h busy=%b want all 0",
               dz, ds, fm, er, busy);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    scan_valid   = 1'b0;
    I            = '0;
    PG           = 1'b0;
    cancel       = 1'b0;
    moneyEntered = 2'b00;
    test_reset();
    test_basic_purchase();
    test_exact_payment();
    test_change_dois();
    test_refund_mixed();
    test_errors();
    test_overflow();
    test_cancel_refund();
    test_back_to_back();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
